noc_inject_arbiter: RTL and testbench

- Shares the single 17-bit injection port of one ring `net_router` between N local requesters, for example a CPU core plus a traffic generator or debug injector.
- Arbitration is round-robin at packet granularity. Once a requester wins, it holds the port until its last flit, so packets stay contiguous.
- Includes a one-flit output register with router backpressure, a stall watchdog and a packet counter.
- Sits between the requesters and the router's free/inject input, one instance per node.

---
 rtl/noc_pkg.sv | 22 ++
 rtl/noc_inject_arbiter_if.sv | 21 ++
 rtl/noc_inject_arbiter_rr_pick.sv | 37 +++
 rtl/noc_inject_arbiter.sv | 129 ++++++++++++
 tb/tb_noc_inject_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit layout constants and arbiter state type
package noc_pkg;

    localparam int FLIT_W         = 17;
    localparam int FLIT_VALID_BIT = 16;
    localparam int BODY_W         = 16;
    localparam int NODE_CNT       = 9;

    // Body field positions; the injection arbiter never decodes them.
    localparam int DEST_HI    = 15;
    localparam int DEST_LO    = 12;
    localparam int SRC_HI     = 11;
    localparam int SRC_LO     = 8;
    localparam int PAYLOAD_HI = 7;
    localparam int PAYLOAD_LO = 0;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/noc_inject_arbiter_if.sv
// rtl/noc_inject_arbiter_if.sv - requester-side bus of the injection arbiter
// Signals (all N requesters packed side by side):
//   req     - per-requester flit-available flag
//   flit_in - per-requester 16-bit body, slice i at [16i+15:16i]
//   last    - per-requester final-flit-of-packet flag
//   gnt     - one-hot "your flit is consumed this edge" pulse
// master: requester side, slave: arbiter side.
interface noc_inject_arbiter_if #(
    parameter int N = 4
);
    import noc_pkg::*;

    logic [N-1:0]        req;
    logic [N*BODY_W-1:0] flit_in;
    logic [N-1:0]        last;
    logic [N-1:0]        gnt;

    modport master (output req, output flit_in, output last, input gnt);
    modport slave  (input req, input flit_in, input last, output gnt);

endinterface

// File: rtl/noc_inject_arbiter_rr_pick.sv
// rtl/noc_inject_arbiter_rr_pick.sv - combinational round-robin picker
// Ports:
//   req_i - request vector
//   ptr_i - index with highest priority this cycle
//   gnt_o - one-hot winner
//   idx_o - winner index
//   any_o - at least one request present
// The scan visits ptr, ptr+1, ... wrapping at N-1, so the first active
// request at or after the pointer wins.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        int j;
        j     = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                idx_o    = IDX_W'(j);
                gnt_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_inject_arbiter.sv
// rtl/noc_inject_arbiter.sv - packet-granular round-robin injection arbiter
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   rq         - requester bus (req/flit_in/last in, gnt out)
//   inj_flit   - registered flit to the router, bit 16 = valid
//   inj_ready  - router accepts inj_flit this cycle
//   owner      - index of the current or last granted requester
//   busy       - packet in progress (LOCK)
//   stall      - watchdog: flit blocked for STALL_MAX cycles
//   pkt_count  - number of last flits loaded, wraps
module noc_inject_arbiter
    import noc_pkg::*;
#(
    parameter int N         = 4,
    parameter int IDX_W     = 2,
    parameter int STALL_MAX = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    noc_inject_arbiter_if.slave   rq,
    output logic [FLIT_W-1:0]     inj_flit,
    input  logic                  inj_ready,
    output logic [IDX_W-1:0]      owner,
    output logic                  busy,
    output logic                  stall,
    output logic [15:0]           pkt_count
);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [FLIT_W-1:0] flit_q, flit_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       sc_q, sc_d;
    logic              stall_q, stall_d;

    logic [N-1:0]      pick_gnt;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;

    logic              ld;
    logic              sel;
    logic              grant;
    logic [IDX_W-1:0]  win;
    logic [N-1:0]      win_oh;

    rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
        .req_i (rq.req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        flit_d  = flit_q;
        cnt_d   = cnt_q;
        sc_d    = '0;
        stall_d = (sc_q == 16'(STALL_MAX));

        // The output register can take a new flit when it is empty or
        // its current flit leaves this edge.
        ld = !flit_q[FLIT_VALID_BIT] || inj_ready;

        // While locked only the owner may be served, so a packet is never
        // interleaved with another requester's flits.
        if (state_q == IDLE) begin
            win    = pick_idx;
            sel    = pick_any;
            win_oh = pick_gnt;
        end else begin
            win    = owner_q;
            sel    = rq.req[owner_q];
            win_oh = N'(1) << owner_q;
        end
        grant = ld && sel;

        if (ld) begin
            flit_d = grant ? {1'b1, rq.flit_in[int'(win)*BODY_W +: BODY_W]} : '0;
        end

        if (grant) begin
            owner_d = win;
            if (rq.last[win]) begin
                state_d = IDLE;
                ptr_d   = (int'(win) == N - 1) ? '0 : win + 1'b1;
                cnt_d   = cnt_q + 16'd1;
            end else begin
                state_d = LOCK;
            end
        end

        if (flit_q[FLIT_VALID_BIT] && !inj_ready) begin
            sc_d = (sc_q == 16'(STALL_MAX)) ? sc_q : sc_q + 16'd1;
        end
    end

    assign rq.gnt = grant ? win_oh : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            flit_q  <= '0;
            cnt_q   <= '0;
            sc_q    <= '0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            flit_q  <= flit_d;
            cnt_q   <= cnt_d;
            sc_q    <= sc_d;
            stall_q <= stall_d;
        end
    end

    assign inj_flit  = flit_q;
    assign owner     = owner_q;
    assign busy      = (state_q == LOCK);
    assign stall     = stall_q;
    assign pkt_count = cnt_q;

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// tb/tb_noc_inject_arbiter.sv - self-checking bench for noc_inject_arbiter
module tb_noc_inject_arbiter;

    localparam int N     = 4;
    localparam int IDX_W = 2;
    localparam int SMAX  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inj_ready = 1'b0;
    logic [16:0] inj_flit;
    logic [1:0]  owner;
    logic        busy;
    logic        stall;
    logic [15:0] pkt_count;

    noc_inject_arbiter_if #(.N(N)) rq ();

    noc_inject_arbiter #(.N(N), .IDX_W(IDX_W), .STALL_MAX(SMAX)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rq        (rq),
        .inj_flit  (inj_flit),
        .inj_ready (inj_ready),
        .owner     (owner),
        .busy      (busy),
        .stall     (stall),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: packet-level view of the port.
    bit          m_valid;
    bit          m_lock;
    logic [15:0] m_body;
    logic [15:0] m_cnt;
    int          m_ptr;
    int          m_owner;
    int          m_sc;
    bit          m_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_lock = 0; m_body = '0; m_cnt = '0;
        m_ptr = 0; m_owner = 0; m_sc = 0; m_stall = 0;
    endtask

    // One clock cycle: predict, compare mid-cycle, advance model, cross edge.
    task automatic step();
        int w;
        bit have, ld, g, blocked;
        w = 0; have = 0;
        ld = !m_valid || inj_ready;
        if (m_lock) begin
            w = m_owner;
            have = rq.req[w];
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!have && rq.req[(m_ptr + k) % N]) begin
                    have = 1;
                    w = (m_ptr + k) % N;
                end
            end
        end
        g = ld && have;
        #3;
        chk("gnt", rq.gnt, g ? (1 << w) : 0);
        chk("valid", inj_flit[16], m_valid);
        if (m_valid) chk("body", inj_flit[15:0], m_body);
        chk("busy", busy, m_lock);
        chk("owner", owner, m_owner);
        chk("stall", stall, m_stall);
        chk("pkt_count", pkt_count, m_cnt);
        blocked = m_valid && !inj_ready;
        m_stall = (m_sc == SMAX);
        m_sc = blocked ? ((m_sc < SMAX) ? m_sc + 1 : SMAX) : 0;
        if (ld) begin
            m_valid = g;
            if (g) m_body = rq.flit_in[w*16 +: 16];
        end
        if (g) begin
            m_owner = w;
            if (rq.last[w]) begin
                m_lock = 0;
                m_ptr = (w + 1) % N;
                m_cnt = m_cnt + 16'd1;
            end else begin
                m_lock = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [3:0]  exp_g [5];
    logic [15:0] body1;

    initial begin
        rq.req = '0; rq.last = '0; rq.flit_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset values
        #1;
        chk("rst_flit", inj_flit, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_stall", stall, 0);
        chk("rst_cnt", pkt_count, 0);
        chk("rst_gnt", rq.gnt, 0);

        // Reset mid-packet (ptr moved to 3 first)
        inj_ready = 1'b1;
        for (int i = 0; i < N; i++) rq.flit_in[i*16 +: 16] = 16'($urandom);
        rq.req = 4'b0100; rq.last = 4'b0100;
        step();
        rq.req = 4'b0001; rq.last = 4'b0000;
        step();
        step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t1_async_flit", inj_flit, 0);
        chk("t1_async_busy", busy, 0);
        chk("t1_async_cnt", pkt_count, 0);
        chk("t1_async_owner", owner, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rq.req = 4'b1010; rq.last = 4'b1010;
        #1;
        chk("t1_gnt_after_rst", rq.gnt, 4'b0010);
        step();

        // Round-robin rotation
        do_reset();
        inj_ready = 1'b1;
        rq.req = 4'b1111; rq.last = 4'b1111;
        for (int i = 0; i < N; i++) rq.flit_in[i*16 +: 16] = 16'(i << 8);
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t2_gnt", rq.gnt, exp_g[k]);
            if (k > 0) chk("t2_flit", inj_flit, 32'h10000 + ((k - 1) << 8));
            if (k == 4) chk("t2_cnt", pkt_count, 4);
            step();
        end

        // Packet lock with others requesting
        do_reset();
        inj_ready = 1'b1;
        for (int i = 0; i < N; i++) rq.flit_in[i*16 +: 16] = 16'($urandom);
        rq.req = 4'b0111; rq.last = 4'b0110;
        #1;
        chk("t3_gnt_f1", rq.gnt, 4'b0001);
        step();
        rq.req = 4'b0110;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t3_gnt_gap", rq.gnt, 4'b0000);
            chk("t3_busy_gap", busy, 1);
            step();
        end
        rq.req = 4'b0111;
        #1;
        chk("t3_gnt_f2", rq.gnt, 4'b0001);
        step();
        rq.last = 4'b0111;
        #1;
        chk("t3_gnt_f3", rq.gnt, 4'b0001);
        chk("t3_busy_f3", busy, 1);
        step();
        #1;
        chk("t3_busy_end", busy, 0);
        chk("t3_gnt_next", rq.gnt, 4'b0010);
        step();

        // Backpressure
        do_reset();
        inj_ready = 1'b1;
        rq.req = 4'b0001; rq.last = 4'b0001;
        step();
        inj_ready = 1'b0;
        rq.req = 4'b0010; rq.last = 4'b0010;
        for (int i = 0; i < N; i++) rq.flit_in[i*16 +: 16] = 16'($urandom);
        body1 = rq.flit_in[31:16];
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t4_gnt_blocked", rq.gnt, 4'b0000);
            step();
        end
        inj_ready = 1'b1;
        #1;
        chk("t4_gnt_release", rq.gnt, 4'b0010);
        step();
        #1;
        chk("t4_flit_next", inj_flit, {15'b0, 1'b1, body1});

        // Watchdog
        inj_ready = 1'b0;
        rq.req = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) chk("t5_stall_early", stall, 0);
            step();
        end
        chk("t5_stall_set", stall, 1);
        inj_ready = 1'b1;
        step();
        inj_ready = 1'b0;
        step();
        chk("t5_stall_clear", stall, 0);

        // Randomised traffic against the model
        do_reset();
        repeat (600) begin
            rq.req = 4'($urandom_range(0, 15));
            rq.last = 4'($urandom);
            inj_ready = ($urandom_range(0, 3) != 0);
            rq.flit_in = {$urandom, $urandom};
            step();
        end

        // Counter wrap
        do_reset();
        inj_ready = 1'b1;
        rq.req = 4'b0001; rq.last = 4'b0001;
        repeat (65534) step();
        chk("t6_cnt_fffe", pkt_count, 16'hFFFE);
        step();
        chk("t6_cnt_ffff", pkt_count, 16'hFFFF);
        step();
        chk("t6_cnt_wrap", pkt_count, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
